viterbi_decoder: RTL and testbench
==================================

Name: viterbi_decoder

Overview:
- Hard-decision Viterbi decoder for the team's (2,1,3) convolutional encoder (K=3, generators g1=111, g0=101).
- Consumes the encoder's 2-bit symbol stream and recovers the original 1-bit data stream.
- Data is recovered in blocks of 8 input bits; the encoder zeroes its state after every block.
- Sits directly downstream of the encoder in the comms-lab chain.

Parameters:
- BLK_LEN, 8, symbols per block. Trellis restarts from state 00 each block. Must match the encoder.
- MW, 5, path-metric width. Must satisfy 2^MW > 2*BLK_LEN+1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- code_in  in  2  received symbol {o1,o0}
- sym_valid  in  1  code_in valid this cycle
- data_out  out  1  decoded bit, serial, oldest bit first
- data_valid  out  1  data_out valid
- word_out  out  BLK_LEN  decoded block, bit 0 = first bit of block
- word_valid  out  1  one-cycle pulse; word_out valid
- locked  out  1  block alignment acquired

Behaviour:
- Reset (async, active-low): all outputs 0; FSM to HUNT; metrics, survivors and counters cleared. A reset mid-block discards the partial block and any pending traceback or output.
- Trellis definition:
  - State s={s1,s0}, where s1 = previous bit and s0 = the bit before it.
  - For input b: o0=b^s0, o1=b^s1^s0; next state={b,s1}.
  - Predecessors of {b,x} are {x,0} and {x,1}; the decoded bit is the MSB of the state.
- HUNT:
  - Ignore valid symbols equal to 00, because the encoder emits 00 until its first 1.
  - The first valid non-00 symbol is symbol 0 of block 0 and is processed immediately.
  - Set locked=1 on the following edge.
- ACS (every valid symbol while locked or on HUNT exit):
  - Branch metric = Hamming distance between code_in and the expected {o1,o0}, range 0..2.
  - At symbol 0 the initial metrics are state00=0 and all other states = all-ones (infinity).
  - New metric = min of the two candidate sums. Tie selects the predecessor with s0=0.
  - Store one survivor bit per state per step in survivor bank A.
  - The symbol counter wraps 0..BLK_LEN-1. sym_valid gaps are allowed and stall the ACS only.
- Block end (symbol BLK_LEN-1 processed):
  - Copy survivors and final metrics into bank B.
  - Start traceback from the minimum-metric state; ties go to the lowest state index.
  - Re-init the metrics for the next block in the same cycle, so back-to-back blocks incur no bubble.
- TRACEBACK:
  - 1 step per cycle, BLK_LEN cycles, runs concurrently with ACS on the next block.
  - Fills the word register from the last bit down to the first.
- OUTPUT:
  - On traceback completion, load word_out, pulse word_valid, and load the serial shift register.
  - data_valid stays high for BLK_LEN consecutive cycles with data_out = bit0, bit1, ...
- Latency is fixed: word_valid rises exactly BLK_LEN+2 cycles after the cycle the last symbol of the block is sampled.
- Symbols arrive at most 1 per cycle, so the next word never overlaps the serial output of the previous word. No backpressure.
- Metric saturation: sums clamp at all-ones, and infinity stays infinity.

Optional Feature:
- VITERBI_ERRCNT_EN defined:
  - Adds output err_cnt [MW-1:0], which holds the winning path metric of the last block (the estimated channel bit errors).
  - err_cnt updates together with word_valid and resets to 0.
- Undefined: the err_cnt port and its register are absent; all other behaviour is identical.

Decomposition:
- Package cv_pkg holds:
  - the state typedef (2 bits)
  - BLK_LEN and MW defaults
  - the INF metric constant
  - the expected-symbol function exp_sym(state,b)
  - the FSM state enum (HUNT, RUN)
- Sub-module cv_acs: one add-compare-select unit with inputs 2 predecessor metrics and 2 branch metrics, and outputs the new metric and survivor bit. Instantiate it 4 times.
- Traceback and output logic stay in the top module.

Test Plan:
- Clean block: data bits 1,0,1,1,0,0,1,0 give symbols 11,10,00,01,01,11,11,10. Required: word_out=8'b01001101, data_out serial 1,0,1,1,0,0,1,0, locked=1. With VITERBI_ERRCNT_EN, err_cnt=0.
- Single error: same stream with symbol 2 changed from 00 to 10. Required: identical word_out, and err_cnt=1.
- Hunt: five valid 00 symbols, then the clean stream. Required: locked stays 0 during the 00s, and the decoded output matches the clean case.
- Back-to-back: three consecutive blocks with sym_valid constantly 1. Required: three word_valid pulses spaced exactly 8 cycles apart, 24 contiguous data_valid cycles, and each pulse BLK_LEN+2 cycles after its block's last symbol.
- Gaps: insert sym_valid=0 on random cycles within a block. Required: same decoded word, with latency measured from the last valid symbol.
- Reset mid-block: assert reset after symbol 4. Required: all outputs 0 immediately and locked=0. A subsequent clean stream decodes correctly.

Source files
------------

// File: rtl/cv_pkg.sv
// cv_pkg: shared types, defaults and trellis helpers
// for the K=3 (7,5) hard-decision Viterbi decoder.
package cv_pkg;

  localparam int BLK_LEN_D = 8;
  localparam int MW_D = 5;
  localparam logic [MW_D-1:0] INF = '1;

  typedef logic [1:0] state_t;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  function automatic logic [1:0] exp_sym(
    input state_t s,
    input logic   b
  );
    return {b ^ s[1] ^ s[0], b ^ s[0]};
  endfunction

  function automatic logic [1:0] ham2(
    input logic [1:0] a,
    input logic [1:0] e
  );
    logic [1:0] d;
    d = a ^ e;
    return {d[1] & d[0], d[1] ^ d[0]};
  endfunction

endpackage

// File: rtl/cv_acs.sv
// cv_acs: one saturating add-compare-select cell.
// Ties resolve to the predecessor with s0=0 (sel=0).
module cv_acs
  import cv_pkg::*;
#(
  parameter int MW = MW_D
) (
  input  logic [MW-1:0] pm0,
  input  logic [MW-1:0] pm1,
  input  logic [1:0]    bm0,
  input  logic [1:0]    bm1,
  output logic [MW-1:0] pm_new,
  output logic          sel
);

  localparam logic [MW-1:0] SAT = '1;

  function automatic logic [MW-1:0] sat_add(
    input logic [MW-1:0] p,
    input logic [1:0]    b
  );
    logic [MW:0] s;
    s = {1'b0, p} + {{(MW-1){1'b0}}, b};
    if (p == SAT || s >= {1'b0, SAT})
      return SAT;
    return s[MW-1:0];
  endfunction

  logic [MW-1:0] s0;
  logic [MW-1:0] s1;

  assign s0     = sat_add(pm0, bm0);
  assign s1     = sat_add(pm1, bm1);
  assign sel    = s1 < s0;
  assign pm_new = sel ? s1 : s0;

endmodule

// File: rtl/viterbi_decoder.sv
// viterbi_decoder: block Viterbi decoder, 4 ACS + traceback.
// Define VITERBI_ERRCNT_EN to add the err_cnt output.
module viterbi_decoder
  import cv_pkg::*;
#(
  parameter int BLK_LEN = BLK_LEN_D,
  parameter int MW      = MW_D
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         code_in,
  input  logic               sym_valid,
  output logic               data_out,
  output logic               data_valid,
  output logic [BLK_LEN-1:0] word_out,
  output logic               word_valid,
`ifdef VITERBI_ERRCNT_EN
  output logic [MW-1:0]      err_cnt,
`endif
  output logic               locked
);

  localparam int CW = $clog2(BLK_LEN);
  localparam logic [CW-1:0] LAST = CW'(BLK_LEN - 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [MW-1:0] INF_M = '1;

  fsm_t          fsm;
  logic [CW-1:0] sym_cnt;
  logic [MW-1:0] pm [4];
  logic [MW-1:0] pm_nx [4];
  logic [3:0]    surv_nx;
  logic [3:0]    surv_a [BLK_LEN];
  logic [3:0]    surv_b [BLK_LEN];
  logic          acs_en;
  logic          blk_end;

  assign acs_en  = sym_valid & ((fsm == RUN) | (code_in != 2'b00));
  assign blk_end = acs_en & (sym_cnt == LAST);

  for (genvar n = 0; n < 4; n++) begin : g_acs
    localparam state_t NS = state_t'(n);
    localparam state_t P0 = {NS[0], 1'b0};
    localparam state_t P1 = {NS[0], 1'b1};
    cv_acs #(.MW(MW)) u_acs (
      .pm0    (pm[P0]),
      .pm1    (pm[P1]),
      .bm0    (ham2(code_in, exp_sym(P0, NS[1]))),
      .bm1    (ham2(code_in, exp_sym(P1, NS[1]))),
      .pm_new (pm_nx[n]),
      .sel    (surv_nx[n])
    );
  end

  // strict compare keeps the lowest index on ties
  state_t        best;
  logic [MW-1:0] best_m;
  always_comb begin
    best   = 2'd0;
    best_m = pm_nx[0];
    for (int i = 1; i < 4; i++) begin
      if (pm_nx[i] < best_m) begin
        best   = state_t'(i);
        best_m = pm_nx[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm     <= HUNT;
      locked  <= 1'b0;
      sym_cnt <= '0;
      for (int i = 0; i < 4; i++)
        pm[i] <= (i == 0) ? '0 : INF_M;
    end else if (acs_en) begin
      fsm     <= RUN;
      locked  <= 1'b1;
      sym_cnt <= blk_end ? '0 : sym_cnt + ONE;
      for (int i = 0; i < 4; i++)
        pm[i] <= blk_end ? ((i == 0) ? '0 : INF_M) : pm_nx[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BLK_LEN; i++)
        surv_a[i] <= '0;
    end else if (acs_en) begin
      surv_a[sym_cnt] <= surv_nx;
    end
  end

  logic [CW-1:0]      tb_idx;
  state_t             tb_st;
  logic               tb_busy;
  logic               last_step;
  logic [BLK_LEN-1:0] word_reg;
  logic [BLK_LEN-1:0] word_hold;
  logic [1:0]         pipe;

  assign last_step = tb_busy & (tb_idx == '0);

  // a new block may start on the same edge as the old final step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BLK_LEN; i++)
        surv_b[i] <= '0;
      tb_idx    <= '0;
      tb_st     <= '0;
      tb_busy   <= 1'b0;
      word_reg  <= '0;
      word_hold <= '0;
      pipe      <= '0;
    end else begin
      if (blk_end) begin
        for (int i = 0; i < BLK_LEN; i++)
          surv_b[i] <= (i == BLK_LEN - 1) ? surv_nx : surv_a[i];
        tb_st   <= best;
        tb_idx  <= LAST;
        tb_busy <= 1'b1;
      end else if (tb_busy) begin
        tb_st   <= {tb_st[0], surv_b[tb_idx][tb_st]};
        tb_idx  <= tb_idx - ONE;
        tb_busy <= ~last_step;
      end
      if (tb_busy)
        word_reg[tb_idx] <= tb_st[1];
      if (last_step)
        word_hold <= {word_reg[BLK_LEN-1:1], tb_st[1]};
      pipe <= {pipe[0], last_step};
    end
  end

  logic [BLK_LEN-1:0] shreg;
  logic [CW-1:0]      out_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      shreg      <= '0;
      out_cnt    <= '0;
    end else begin
      word_valid <= pipe[1];
      if (pipe[1]) begin
        word_out   <= word_hold;
        data_out   <= word_hold[0];
        data_valid <= 1'b1;
        shreg      <= word_hold >> 1;
        out_cnt    <= LAST;
      end else if (data_valid && out_cnt != '0) begin
        data_out <= shreg[0];
        shreg    <= shreg >> 1;
        out_cnt  <= out_cnt - ONE;
      end else begin
        data_out   <= 1'b0;
        data_valid <= 1'b0;
      end
    end
  end

`ifdef VITERBI_ERRCNT_EN
  logic [MW-1:0] win_m;
  logic [MW-1:0] win_hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_m    <= '0;
      win_hold <= '0;
      err_cnt  <= '0;
    end else begin
      if (blk_end)
        win_m <= best_m;
      if (last_step)
        win_hold <= win_m;
      if (pipe[1])
        err_cnt <= win_hold;
    end
  end
`endif

endmodule

// File: tb/tb_viterbi_decoder.sv
// tb_viterbi_decoder: directed tests for viterbi_decoder.
// Expected words and symbol streams are hand-encoded.
`timescale 1ns/1ps
module tb_viterbi_decoder;

  localparam int BL = 8;
  localparam int MW = 5;
  localparam int LAT = BL + 2;

  localparam logic [15:0] CLEAN  = 16'b11_10_00_01_01_11_11_10;
  localparam logic [15:0] ONEERR = 16'b11_10_10_01_01_11_11_10;
  localparam logic [15:0] BLK2   = 16'b00_11_01_01_11_00_11_01;
  localparam logic [15:0] BLK3   = 16'b11_01_10_10_10_10_10_10;
  localparam logic [7:0]  W1 = 8'b01001101;
  localparam logic [7:0]  W2 = 8'b11000110;
  localparam logic [7:0]  W3 = 8'b11111111;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    code_in = 2'b00;
  logic          sym_valid = 1'b0;
  logic          data_out;
  logic          data_valid;
  logic [BL-1:0] word_out;
  logic          word_valid;
  logic          locked;
`ifdef VITERBI_ERRCNT_EN
  logic [MW-1:0] err_cnt;
  logic [MW-1:0] ec_q[$];
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;
  int wv_q[$];
  logic [BL-1:0] wd_q[$];
  int dv_q[$];
  logic do_q[$];

  viterbi_decoder #(.BLK_LEN(BL), .MW(MW)) dut (
    .clk        (clk),
    .reset      (reset),
    .code_in    (code_in),
    .sym_valid  (sym_valid),
    .data_out   (data_out),
    .data_valid (data_valid),
    .word_out   (word_out),
    .word_valid (word_valid),
`ifdef VITERBI_ERRCNT_EN
    .err_cnt    (err_cnt),
`endif
    .locked     (locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (word_valid) begin
      wv_q.push_back(cyc);
      wd_q.push_back(word_out);
`ifdef VITERBI_ERRCNT_EN
      ec_q.push_back(err_cnt);
`endif
    end
    if (data_valid) begin
      dv_q.push_back(cyc);
      do_q.push_back(data_out);
    end
  end

  task automatic clear_q();
    wv_q.delete();
    wd_q.delete();
    dv_q.delete();
    do_q.delete();
`ifdef VITERBI_ERRCNT_EN
    ec_q.delete();
`endif
  endtask

  task automatic send_sym(input logic [1:0] c);
    @(negedge clk);
    code_in   = c;
    sym_valid = 1'b1;
    last_cyc  = cyc + 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sym_valid = 1'b0;
      code_in   = 2'b00;
    end
  endtask

  task automatic send_blk(input logic [15:0] v, input logic [7:0] gaps);
    for (int i = 0; i < BL; i++) begin
      if (gaps[i]) idle(1);
      send_sym(v[15-2*i -: 2]);
    end
  endtask

  task automatic wait_out(input int nw, output bit ok);
    int t;
    t = 0;
    while ((wv_q.size() < nw || dv_q.size() < BL*nw) && t < 40*nw) begin
      @(negedge clk);
      #1;
      t++;
    end
    ok = (wv_q.size() >= nw) && (dv_q.size() >= BL*nw);
    idle(2);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({word_valid, data_valid, data_out, locked} !== 4'b0000 ||
        word_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs got wv=%b dv=%b do=%b lk=%b wo=%b want 0",
               word_valid, data_valid, data_out, locked, word_out);
    end
`ifdef VITERBI_ERRCNT_EN
    checks++;
    if (err_cnt !== '0) begin
      errors++;
      $display("FAIL reset_errcnt got %0d want 0", err_cnt);
    end
`endif
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    #1;
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_locked got %b want 0", locked);
    end
  endtask

  task automatic test_clean();
    bit ok;
    logic [7:0] w;
    w = W1;
    clear_q();
    send_blk(CLEAN, 8'h00);
    #1;
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL clean_locked got %b want 1", locked);
    end
    idle(1);
    wait_out(1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL clean_timeout got %0d words want 1", wv_q.size());
    end else begin
      checks++;
      if (wd_q[0] !== w) begin
        errors++;
        $display("FAIL clean_word got %b want %b", wd_q[0], w);
      end
      checks++;
      if (wv_q[0] - last_cyc != LAT) begin
        errors++;
        $display("FAIL clean_latency got %0d want %0d", wv_q[0] - last_cyc, LAT);
      end
      checks++;
      if (dv_q[0] != wv_q[0] || dv_q[BL-1] - dv_q[0] != BL - 1) begin
        errors++;
        $display("FAIL clean_dv_span got %0d..%0d want %0d..%0d",
                 dv_q[0], dv_q[BL-1], wv_q[0], wv_q[0] + BL - 1);
      end
      for (int i = 0; i < BL; i++) begin
        checks++;
        if (do_q[i] !== w[i]) begin
          errors++;
          $display("FAIL clean_bit%0d got %b want %b", i, do_q[i], w[i]);
        end
      end
`ifdef VITERBI_ERRCNT_EN
      checks++;
      if (ec_q[0] !== 5'd0) begin
        errors++;
        $display("FAIL clean_errcnt got %0d want 0", ec_q[0]);
      end
`endif
    end
  endtask

  task automatic test_single_err();
    bit ok;
    logic [7:0] w;
    w = W1;
    clear_q();
    send_blk(ONEERR, 8'h00);
    idle(1);
    wait_out(1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL oneerr_timeout got %0d words want 1", wv_q.size());
    end else begin
      checks++;
      if (wd_q[0] !== w) begin
        errors++;
        $display("FAIL oneerr_word got %b want %b", wd_q[0], w);
      end
      for (int i = 0; i < BL; i++) begin
        checks++;
        if (do_q[i] !== w[i]) begin
          errors++;
          $display("FAIL oneerr_bit%0d got %b want %b", i, do_q[i], w[i]);
        end
      end
`ifdef VITERBI_ERRCNT_EN
      checks++;
      if (ec_q[0] !== 5'd1) begin
        errors++;
        $display("FAIL oneerr_errcnt got %0d want 1", ec_q[0]);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int lc[3];
    logic [7:0] ew[3];
    logic [7:0] w;
    ew[0] = W1;
    ew[1] = W2;
    ew[2] = W3;
    clear_q();
    send_blk(CLEAN, 8'h00);
    lc[0] = last_cyc;
    send_blk(BLK2, 8'h00);
    lc[1] = last_cyc;
    send_blk(BLK3, 8'h00);
    lc[2] = last_cyc;
    idle(1);
    wait_out(3, ok);
    checks++;
    if (!ok || wv_q.size() != 3) begin
      errors++;
      $display("FAIL b2b_count got %0d words want 3", wv_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        w = ew[k];
        checks++;
        if (wd_q[k] !== w) begin
          errors++;
          $display("FAIL b2b_word%0d got %b want %b", k, wd_q[k], w);
        end
        checks++;
        if (wv_q[k] - lc[k] != LAT) begin
          errors++;
          $display("FAIL b2b_latency%0d got %0d want %0d", k, wv_q[k] - lc[k], LAT);
        end
        if (k > 0) begin
          checks++;
          if (wv_q[k] - wv_q[k-1] != BL) begin
            errors++;
            $display("FAIL b2b_spacing%0d got %0d want %0d",
                     k, wv_q[k] - wv_q[k-1], BL);
          end
        end
        for (int i = 0; i < BL; i++) begin
          checks++;
          if (do_q[k*BL+i] !== w[i]) begin
            errors++;
            $display("FAIL b2b_bit%0d_%0d got %b want %b",
                     k, i, do_q[k*BL+i], w[i]);
          end
        end
      end
      checks++;
      if (dv_q.size() != 3*BL || dv_q[3*BL-1] - dv_q[0] != 3*BL - 1) begin
        errors++;
        $display("FAIL b2b_dv_contig got %0d cycles span %0d want %0d",
                 dv_q.size(), dv_q[dv_q.size()-1] - dv_q[0], 3*BL - 1);
      end
    end
  endtask

  task automatic test_gaps();
    bit ok;
    int lc[2];
    logic [7:0] g;
    logic [7:0] ew[2];
    logic [7:0] w;
    ew[0] = W1;
    ew[1] = W2;
    clear_q();
    send_blk(CLEAN, 8'b0101_0110);
    lc[0] = last_cyc;
    g = 8'($urandom_range(0, 255));
    send_blk(BLK2, g);
    lc[1] = last_cyc;
    idle(1);
    wait_out(2, ok);
    checks++;
    if (!ok || wv_q.size() != 2) begin
      errors++;
      $display("FAIL gaps_count got %0d words want 2", wv_q.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        w = ew[k];
        checks++;
        if (wd_q[k] !== w) begin
          errors++;
          $display("FAIL gaps_word%0d got %b want %b (g=%b)", k, wd_q[k], w, g);
        end
        checks++;
        if (wv_q[k] - lc[k] != LAT) begin
          errors++;
          $display("FAIL gaps_latency%0d got %0d want %0d", k, wv_q[k] - lc[k], LAT);
        end
        for (int i = 0; i < BL; i++) begin
          checks++;
          if (do_q[k*BL+i] !== w[i]) begin
            errors++;
            $display("FAIL gaps_bit%0d_%0d got %b want %b",
                     k, i, do_q[k*BL+i], w[i]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [15:0] v;
    logic [7:0] w;
    v = BLK2;
    w = W1;
    clear_q();
    send_blk(CLEAN, 8'h00);
    idle(6);
    for (int i = 0; i < 5; i++)
      send_sym(v[15-2*i -: 2]);
    @(negedge clk);
    sym_valid = 1'b0;
    code_in   = 2'b00;
    #1;
    checks++;
    if (data_valid !== 1'b1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre got dv=%b lk=%b want 1 1", data_valid, locked);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({word_valid, data_valid, data_out, locked} !== 4'b0000 ||
        word_out !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got wv=%b dv=%b do=%b lk=%b wo=%b want 0",
               word_valid, data_valid, data_out, locked, word_out);
    end
    @(negedge clk);
    reset = 1'b1;
    clear_q();
    idle(25);
    checks++;
    if (wv_q.size() != 0 || dv_q.size() != 0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_discard got words=%0d bits=%0d lk=%b want 0 0 0",
               wv_q.size(), dv_q.size(), locked);
    end
    send_blk(CLEAN, 8'h00);
    idle(1);
    wait_out(1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rstmid_timeout got %0d words want 1", wv_q.size());
    end else begin
      checks++;
      if (wd_q[0] !== w || wv_q[0] - last_cyc != LAT) begin
        errors++;
        $display("FAIL rstmid_word got %b lat %0d want %b lat %0d",
                 wd_q[0], wv_q[0] - last_cyc, w, LAT);
      end
      for (int i = 0; i < BL; i++) begin
        checks++;
        if (do_q[i] !== w[i]) begin
          errors++;
          $display("FAIL rstmid_bit%0d got %b want %b", i, do_q[i], w[i]);
        end
      end
    end
  endtask

  task automatic test_hunt();
    bit ok;
    logic [7:0] w;
    w = W1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    clear_q();
    for (int i = 0; i < 5; i++) begin
      send_sym(2'b00);
      #1;
      checks++;
      if (locked !== 1'b0) begin
        errors++;
        $display("FAIL hunt_locked%0d got %b want 0", i, locked);
      end
    end
    idle(1);
    #1;
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL hunt_locked_end got %b want 0", locked);
    end
    send_blk(CLEAN, 8'h00);
    #1;
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL hunt_lock_acq got %b want 1", locked);
    end
    idle(1);
    wait_out(1, ok);
    checks++;
    if (!ok || wv_q.size() != 1) begin
      errors++;
      $display("FAIL hunt_count got %0d words want 1", wv_q.size());
    end else begin
      checks++;
      if (wd_q[0] !== w || wv_q[0] - last_cyc != LAT) begin
        errors++;
        $display("FAIL hunt_word got %b lat %0d want %b lat %0d",
                 wd_q[0], wv_q[0] - last_cyc, w, LAT);
      end
      for (int i = 0; i < BL; i++) begin
        checks++;
        if (do_q[i] !== w[i]) begin
          errors++;
          $display("FAIL hunt_bit%0d got %b want %b", i, do_q[i], w[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_err();
    test_back_to_back();
    test_gaps();
    test_reset_mid();
    test_hunt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
